// File: rtl/dualport_bus_arbiter.sv
// dualport_bus_arbiter: two masters share one dual-port slave through independent rd/wr arbiters; DPBUS_ARB_PERF_EN adds grant/conflict counters
module dualport_bus_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BE_W = 4,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_rd_req_i,
  input  logic [BE_W-1:0]   m0_rd_be_i,
  input  logic [ADDR_W-1:0] m0_rd_addr_i,
  output logic              m0_rd_gnt_o,
  output logic [DATA_W-1:0] m0_rd_data_o,
  input  logic              m0_wr_req_i,
  input  logic [BE_W-1:0]   m0_wr_be_i,
  input  logic [ADDR_W-1:0] m0_wr_addr_i,
  input  logic [DATA_W-1:0] m0_wr_data_i,
  output logic              m0_wr_gnt_o,
  input  logic              m1_rd_req_i,
  input  logic [BE_W-1:0]   m1_rd_be_i,
  input  logic [ADDR_W-1:0] m1_rd_addr_i,
  output logic              m1_rd_gnt_o,
  output logic [DATA_W-1:0] m1_rd_data_o,
  input  logic              m1_wr_req_i,
  input  logic [BE_W-1:0]   m1_wr_be_i,
  input  logic [ADDR_W-1:0] m1_wr_addr_i,
  input  logic [DATA_W-1:0] m1_wr_data_i,
  output logic              m1_wr_gnt_o,
  output logic              s_rd_req_o,
  output logic [BE_W-1:0]   s_rd_be_o,
  output logic [ADDR_W-1:0] s_rd_addr_o,
  input  logic              s_rd_gnt_i,
  input  logic [DATA_W-1:0] s_rd_data_i,
  output logic              s_wr_req_o,
  output logic [BE_W-1:0]   s_wr_be_o,
  output logic [ADDR_W-1:0] s_wr_addr_o,
  output logic [DATA_W-1:0] s_wr_data_o,
  input  logic              s_wr_gnt_i
`ifdef DPBUS_ARB_PERF_EN
  ,
  output logic [31:0]       perf_rd_cnt0_o,
  output logic [31:0]       perf_rd_cnt1_o,
  output logic [31:0]       perf_wr_cnt0_o,
  output logic [31:0]       perf_wr_cnt1_o,
  output logic [31:0]       perf_rd_conflict_o,
  output logic [31:0]       perf_wr_conflict_o
`endif
);
  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;
  localparam int RPL_W = BE_W + ADDR_W;
  localparam int WPL_W = BE_W + ADDR_W + DATA_W;
  // index 0 = read channel, 1 = write channel
  state_e state_q [2];
  state_e state_d [2];
  logic [1:0] rr_q, rr_d, req0, req1, s_gnt, pick1, load, s_req, gnt0, gnt1;
  logic [RPL_W-1:0] rd_pl_q, rd_pl_d;
  logic [WPL_W-1:0] wr_pl_q, wr_pl_d;
  assign req0 = {m0_wr_req_i, m0_rd_req_i};
  assign req1 = {m1_wr_req_i, m1_rd_req_i};
  assign s_gnt = {s_wr_gnt_i, s_rd_gnt_i};
  always_ff @(posedge clk)
    if (!rst_n) begin
      state_q <= '{IDLE, IDLE};
      rr_q <= '0;
      rd_pl_q <= '0;
      wr_pl_q <= '0;
    end else begin
      state_q <= state_d;
      rr_q <= rr_d;
      rd_pl_q <= rd_pl_d;
      wr_pl_q <= wr_pl_d;
    end
  // m1 wins when alone, or on a tie when round-robin points at it
  always_comb begin
    for (int c = 0; c < 2; c++) begin
      pick1[c] = req1[c] & (~req0[c] | (FIXED_PRIO == 0 && rr_q[c]));
      load[c] = state_q[c] == IDLE && (req0[c] | req1[c]);
      state_d[c] = state_q[c] == IDLE ? (load[c] ? (pick1[c] ? OWN1 : OWN0) : IDLE)
                                      : (s_gnt[c] ? IDLE : state_q[c]);
      rr_d[c] = (state_q[c] != IDLE && s_gnt[c]) ? state_q[c] == OWN0 : rr_q[c];
    end
    rd_pl_d = load[0] ? (pick1[0] ? {m1_rd_be_i, m1_rd_addr_i} : {m0_rd_be_i, m0_rd_addr_i}) : rd_pl_q;
    wr_pl_d = load[1] ? (pick1[1] ? {m1_wr_be_i, m1_wr_addr_i, m1_wr_data_i}
                                  : {m0_wr_be_i, m0_wr_addr_i, m0_wr_data_i}) : wr_pl_q;
  end
  always_comb
    for (int c = 0; c < 2; c++) begin
      s_req[c] = state_q[c] != IDLE;
      gnt0[c] = state_q[c] == OWN0 && s_gnt[c];
      gnt1[c] = state_q[c] == OWN1 && s_gnt[c];
    end
  assign s_rd_req_o = s_req[0];
  assign s_wr_req_o = s_req[1];
  assign {s_rd_be_o, s_rd_addr_o} = rd_pl_q;
  assign {s_wr_be_o, s_wr_addr_o, s_wr_data_o} = wr_pl_q;
  assign m0_rd_gnt_o = gnt0[0];
  assign m1_rd_gnt_o = gnt1[0];
  assign m0_wr_gnt_o = gnt0[1];
  assign m1_wr_gnt_o = gnt1[1];
  assign m0_rd_data_o = s_rd_data_i;
  assign m1_rd_data_o = s_rd_data_i;
`ifdef DPBUS_ARB_PERF_EN
  logic [5:0] inc;
  logic [31:0] perf_q [6];
  assign inc = {state_q[1] == IDLE && req0[1] && req1[1], state_q[0] == IDLE && req0[0] && req1[0],
                gnt1[1], gnt0[1], gnt1[0], gnt0[0]};
  always_ff @(posedge clk)
    for (int i = 0; i < 6; i++)
      if (!rst_n) perf_q[i] <= '0;
      else if (inc[i] && ~&perf_q[i]) perf_q[i] <= perf_q[i] + 32'd1;
  assign perf_rd_cnt0_o = perf_q[0];
  assign perf_rd_cnt1_o = perf_q[1];
  assign perf_wr_cnt0_o = perf_q[2];
  assign perf_wr_cnt1_o = perf_q[3];
  assign perf_rd_conflict_o = perf_q[4];
  assign perf_wr_conflict_o = perf_q[5];
`endif
endmodule

// File: tb/tb_dualport_bus_arbiter.sv
// tb_dualport_bus_arbiter: round-robin (k=0) and fixed-priority (k=1) instances checked against a transaction-level model
module tb_dualport_bus_arbiter;
  typedef struct {int m; logic [3:0] be; logic [31:0] addr; logic [31:0] data;} txn_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  // [k][c][m]: k = instance, c = channel (0 rd, 1 wr), m = master
  logic req [2][2][2];
  logic [3:0] be [2][2][2];
  logic [31:0] addr [2][2][2];
  logic [31:0] wdata [2][2];
  logic gnt [2][2][2];
  logic [31:0] rdata [2][2];
  logic s_req [2][2];
  logic [3:0] s_be [2][2];
  logic [31:0] s_addr [2][2];
  logic [31:0] s_wdata [2];
  logic s_gnt [2][2];
  logic [31:0] s_rdata [2];
  logic seen [2][2][2];
  int left [2][2][2];
  int owner [2][2];
  int rr [2][2];
  txn_t exp_q [4][$];
  int ord [2][$];
  int exp_ord [2][4] = '{'{0, 1, 0, 1}, '{0, 0, 1, 1}};
  int checks = 0, errors = 0, gp = 100;
  bit rnd = 0, stray = 0, mon_en = 0;
`ifdef DPBUS_ARB_PERF_EN
  logic [31:0] perf [2][6];
  int mcnt [2][6];
`endif
  for (genvar k = 0; k < 2; k++) begin : g_dut
    dualport_bus_arbiter #(.FIXED_PRIO(k)) dut (
      .clk(clk), .rst_n(rst_n),
      .m0_rd_req_i(req[k][0][0]), .m0_rd_be_i(be[k][0][0]), .m0_rd_addr_i(addr[k][0][0]),
      .m0_rd_gnt_o(gnt[k][0][0]), .m0_rd_data_o(rdata[k][0]),
      .m0_wr_req_i(req[k][1][0]), .m0_wr_be_i(be[k][1][0]), .m0_wr_addr_i(addr[k][1][0]),
      .m0_wr_data_i(wdata[k][0]), .m0_wr_gnt_o(gnt[k][1][0]),
      .m1_rd_req_i(req[k][0][1]), .m1_rd_be_i(be[k][0][1]), .m1_rd_addr_i(addr[k][0][1]),
      .m1_rd_gnt_o(gnt[k][0][1]), .m1_rd_data_o(rdata[k][1]),
      .m1_wr_req_i(req[k][1][1]), .m1_wr_be_i(be[k][1][1]), .m1_wr_addr_i(addr[k][1][1]),
      .m1_wr_data_i(wdata[k][1]), .m1_wr_gnt_o(gnt[k][1][1]),
      .s_rd_req_o(s_req[k][0]), .s_rd_be_o(s_be[k][0]), .s_rd_addr_o(s_addr[k][0]),
      .s_rd_gnt_i(s_gnt[k][0]), .s_rd_data_i(s_rdata[k]),
      .s_wr_req_o(s_req[k][1]), .s_wr_be_o(s_be[k][1]), .s_wr_addr_o(s_addr[k][1]),
      .s_wr_data_o(s_wdata[k]), .s_wr_gnt_i(s_gnt[k][1])
`ifdef DPBUS_ARB_PERF_EN
      ,
      .perf_rd_cnt0_o(perf[k][0]), .perf_rd_cnt1_o(perf[k][1]),
      .perf_wr_cnt0_o(perf[k][2]), .perf_wr_cnt1_o(perf[k][3]),
      .perf_rd_conflict_o(perf[k][4]), .perf_wr_conflict_o(perf[k][5])
`endif
    );
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask
  // reference model: one arbitration decision per idle channel, one completion per slave grant
  initial forever begin
    @(posedge clk);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++)
        if (!rst_n) begin
          owner[k][c] = -1;
          rr[k][c] = 0;
          exp_q[k*2+c].delete();
`ifdef DPBUS_ARB_PERF_EN
          for (int i = 0; i < 6; i++) mcnt[k][i] = 0;
`endif
        end else if (owner[k][c] < 0) begin
          if (req[k][c][0] || req[k][c][1]) begin
            owner[k][c] = !req[k][c][1] ? 0 : !req[k][c][0] ? 1 : (k == 1) ? 0 : rr[k][c];
            exp_q[k*2+c].push_back('{owner[k][c], be[k][c][owner[k][c]], addr[k][c][owner[k][c]],
                                     wdata[k][owner[k][c]]});
`ifdef DPBUS_ARB_PERF_EN
            if (req[k][c][0] && req[k][c][1]) mcnt[k][4+c]++;
`endif
          end
        end else if (s_gnt[k][c]) begin
`ifdef DPBUS_ARB_PERF_EN
          mcnt[k][2*c+owner[k][c]]++;
`endif
          rr[k][c] = 1 - owner[k][c];
          owner[k][c] = -1;
        end
  end
  // monitor: the queue head is the transaction the slave should currently see
  initial begin
    txn_t t;
    logic [31:0] eg;
    forever begin
      @(negedge clk);
      if (mon_en)
        for (int k = 0; k < 2; k++)
          for (int c = 0; c < 2; c++) begin
            chk($sformatf("k%0d c%0d s_req", k, c), 32'(s_req[k][c]), 32'(exp_q[k*2+c].size() != 0));
            eg = 0;
            if (exp_q[k*2+c].size() != 0) begin
              t = exp_q[k*2+c][0];
              chk($sformatf("k%0d c%0d s_be", k, c), 32'(s_be[k][c]), 32'(t.be));
              chk($sformatf("k%0d c%0d s_addr", k, c), s_addr[k][c], t.addr);
              if (c == 1) chk($sformatf("k%0d s_wdata", k), s_wdata[k], t.data);
              if (s_gnt[k][c]) begin
                eg = 32'(1) << t.m;
                if (c == 0) begin
                  chk($sformatf("k%0d m%0d rd_data", k, t.m), rdata[k][t.m], s_rdata[k]);
                  ord[k].push_back(t.m);
                end
                void'(exp_q[k*2+c].pop_front());
              end
            end
            chk($sformatf("k%0d c%0d gnt", k, c), 32'({gnt[k][c][1], gnt[k][c][0]}), eg);
          end
    end
  end
  task automatic step();
    @(negedge clk);
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++)
        for (int m = 0; m < 2; m++) seen[k][c][m] = gnt[k][c][m];
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        for (int m = 0; m < 2; m++)
          if (rnd) begin
            if (seen[k][c][m] || !req[k][c][m]) begin
              req[k][c][m] = $urandom_range(0, 2) != 0;
              be[k][c][m] = 4'($urandom);
              addr[k][c][m] = $urandom;
              if (c == 1) wdata[k][m] = $urandom;
            end else if ($urandom_range(0, 31) == 0) req[k][c][m] = 1'b0;
          end else if (seen[k][c][m] && left[k][c][m] > 0) begin
            left[k][c][m]--;
            req[k][c][m] = left[k][c][m] > 0;
          end
        s_gnt[k][c] = s_req[k][c] ? $urandom_range(0, 99) < gp : stray && $urandom_range(0, 3) == 0;
      end
      if (rnd) s_rdata[k] = $urandom;
    end
  endtask
  task automatic set_req(int c, int m, logic [31:0] a, logic [3:0] b, logic [31:0] d, int n);
    for (int k = 0; k < 2; k++) begin
      req[k][c][m] = 1'b1;
      addr[k][c][m] = a;
      be[k][c][m] = b;
      if (c == 1) wdata[k][m] = d;
      left[k][c][m] = n;
    end
  endtask
  task automatic clear_req();
    for (int k = 0; k < 2; k++)
      for (int c = 0; c < 2; c++)
        for (int m = 0; m < 2; m++) begin
          req[k][c][m] = 1'b0;
          left[k][c][m] = 0;
        end
  endtask
  task automatic do_reset();
    clear_req();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask
  initial begin
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 2; c++) begin
        for (int m = 0; m < 2; m++) begin
          be[k][c][m] = '0;
          addr[k][c][m] = '0;
          seen[k][c][m] = 1'b0;
          wdata[k][m] = '0;
        end
        s_gnt[k][c] = 1'b0;
      end
      s_rdata[k] = '0;
    end
    clear_req();
    @(posedge clk);
    #1;
    mon_en = 1;
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d rst s_rd_addr", k), s_addr[k][0], 0);
      chk($sformatf("k%0d rst s_wr_addr", k), s_addr[k][1], 0);
      chk($sformatf("k%0d rst s_wr_data", k), s_wdata[k], 0);
    end
    repeat (5) step();
    // single read, slave grants on the second request cycle
    set_req(0, 0, 32'h100, 4'hF, 0, 1);
    for (int k = 0; k < 2; k++) s_rdata[k] = 32'hDEADBEEF;
    gp = 0;
    step();
    gp = 100;
    repeat (4) step();
    // contention with a zero-wait slave
    do_reset();
    for (int k = 0; k < 2; k++) ord[k].delete();
    set_req(0, 0, 32'h200, 4'hF, 0, 2);
    set_req(0, 1, 32'h300, 4'hC, 0, 2);
    repeat (12) step();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("k%0d order_len", k), ord[k].size(), 4);
      for (int i = 0; i < 4; i++)
        if (i < ord[k].size()) chk($sformatf("k%0d order%0d", k, i), ord[k][i], exp_ord[k][i]);
    end
    // concurrent write from m0 and read from m1
    do_reset();
    set_req(1, 0, 32'h20, 4'h3, 32'h55AA55AA, 1);
    set_req(0, 1, 32'h40, 4'hF, 0, 1);
    step();
    for (int k = 0; k < 2; k++)
      chk($sformatf("k%0d both_req", k), 32'({s_req[k][1], s_req[k][0]}), 32'h3);
    repeat (3) step();
    // reset while the slave stalls in OWN1, then stray slave grants while idle
    do_reset();
    set_req(0, 1, 32'h80, 4'hF, 0, 1);
    gp = 0;
    repeat (3) step();
    clear_req();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) chk($sformatf("k%0d mid_rst s_rd_req", k), 32'(s_req[k][0]), 0);
    stray = 1;
    gp = 100;
    repeat (10) step();
    // random traffic with varying slave wait states
    rnd = 1;
    for (int p = 0; p < 4; p++) begin
      gp = p == 0 ? 100 : int'($urandom_range(20, 80));
      if (p == 2) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      repeat (1500) step();
    end
`ifdef DPBUS_ARB_PERF_EN
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 6; i++) chk($sformatf("k%0d perf%0d", k, i), perf[k][i], mcnt[k][i]);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
